// File: rtl/pipe_scoreboard.sv
// Purpose : in-order pipeline scoreboard; tracks writers in EX..WB and decides stall/forwarding for decode.
// Latency : stall/issue_ready are combinational; fwd_a/fwd_b register one cycle after issue (instruction in EX).
// Backpressure: hold freezes all state; stall and flush block issue_ready; no pending instruction is stored.
//
// Ports:
//   clk, reset                 rising-edge clock, asynchronous active-low reset
//   issue_valid/wen/load/rd    decode instruction and its destination
//   src_a/src_b(+_used)        decode source registers and whether they are read
//   flush                      squash decode and EX-stage instruction
//   hold                       global freeze
//   issue_ready, stall         accept / data-hazard stall for decode (combinational)
//   fwd_a, fwd_b               forward selects for the instruction in EX (0 = regfile, k = stage k)
//   stall_count                saturating count of stall cycles
module pipe_scoreboard #(
   parameter int DEPTH      = 3,
   parameter int REG_AW     = 5,
   parameter int ALU_READY  = 2,
   parameter int LOAD_READY = 3,
   localparam int FW        = $clog2(DEPTH + 1)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              issue_valid,
   input  logic              issue_wen,
   input  logic              issue_load,
   input  logic [REG_AW-1:0] issue_rd,
   input  logic [REG_AW-1:0] src_a,
   input  logic [REG_AW-1:0] src_b,
   input  logic              src_a_used,
   input  logic              src_b_used,
   input  logic              flush,
   input  logic              hold,
   output logic              issue_ready,
   output logic              stall,
   output logic [FW-1:0]     fwd_a,
   output logic [FW-1:0]     fwd_b,
   output logic [15:0]       stall_count
);

   // Per-stage entry, index k = 1 (EX) .. DEPTH (WB)
   logic [DEPTH:1]    r_vld;
   logic [DEPTH:1]    r_wen;
   logic [DEPTH:1]    r_load;
   logic [REG_AW-1:0] r_rd [1:DEPTH];

   logic [FW-1:0]     r_fwd_a;
   logic [FW-1:0]     r_fwd_b;
   logic [15:0]       r_stall_cnt;

   logic [FW-1:0]     w_sel_a;
   logic [FW-1:0]     w_sel_b;
   logic              w_late_a;
   logic              w_late_b;
   logic              w_stall;
   logic              w_issue_ready;

   // Scan from oldest matchable stage down to EX so the youngest match is
   // the last one written. The WB entry is never matched: the register file
   // is written first and read after in the same cycle.
   // w_sel_x holds (k+1): the stage the producer will occupy when the
   // consumer reaches EX, which is exactly the registered forward select.
   always_comb begin
      w_sel_a  = '0;
      w_sel_b  = '0;
      w_late_a = 1'b0;
      w_late_b = 1'b0;
      for (int k = DEPTH - 1; k >= 1; k--) begin
         if (src_a_used && (src_a != '0) && r_vld[k] && r_wen[k] && (r_rd[k] == src_a)) begin
            w_sel_a  = FW'(k + 1);
            w_late_a = (k + 1) < (r_load[k] ? LOAD_READY : ALU_READY);
         end
         if (src_b_used && (src_b != '0) && r_vld[k] && r_wen[k] && (r_rd[k] == src_b)) begin
            w_sel_b  = FW'(k + 1);
            w_late_b = (k + 1) < (r_load[k] ? LOAD_READY : ALU_READY);
         end
      end
   end

   // flush outranks any hazard; hold only blocks acceptance, stall stays visible
   assign w_stall       = issue_valid & ~flush & (w_late_a | w_late_b);
   assign w_issue_ready = issue_valid & ~w_stall & ~hold & ~flush;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_vld       <= '0;
         r_wen       <= '0;
         r_load      <= '0;
         for (int k = 1; k <= DEPTH; k++) begin
            r_rd[k] <= '0;
         end
         r_fwd_a     <= '0;
         r_fwd_b     <= '0;
         r_stall_cnt <= '0;
      end else if (!hold) begin
         for (int k = DEPTH; k >= 2; k--) begin
            r_vld[k]  <= r_vld[k-1];
            r_wen[k]  <= r_wen[k-1];
            r_load[k] <= r_load[k-1];
            r_rd[k]   <= r_rd[k-1];
         end
         // squashed EX instruction becomes a bubble as it moves on
         if (flush) begin
            r_vld[2] <= 1'b0;
         end
         r_vld[1]  <= w_issue_ready;
         r_wen[1]  <= issue_wen;
         r_load[1] <= issue_load;
         r_rd[1]   <= issue_rd;
         r_fwd_a   <= w_issue_ready ? w_sel_a : '0;
         r_fwd_b   <= w_issue_ready ? w_sel_b : '0;
         if (w_stall && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
         end
      end
   end

   assign issue_ready = w_issue_ready;
   assign stall       = w_stall;
   assign fwd_a       = r_fwd_a;
   assign fwd_b       = r_fwd_b;
   assign stall_count = r_stall_cnt;

endmodule

// File: tb/tb_pipe_scoreboard.sv
// Purpose : self-checking bench for pipe_scoreboard (DEPTH=3 main instance, DEPTH=8 saturation instance).
// Latency : expected forward selects queued at issue, compared one cycle later in EX.
// Backpressure: hold/stall/flush modelled cycle by cycle against an independent pipeline model.
module tb_pipe_scoreboard;

   localparam int D        = 3;
   localparam int ALU_RDY  = 2;
   localparam int LOAD_RDY = 3;

   logic       clk;
   logic       reset;
   logic       issue_valid, issue_wen, issue_load;
   logic [4:0] issue_rd, src_a, src_b;
   logic       src_a_used, src_b_used, flush, hold;
   logic       issue_ready, stall;
   logic [1:0] fwd_a, fwd_b;
   logic [15:0] stall_count;

   // saturation instance: DEPTH=8, load ready only at WB -> 6 stalls every 7 cycles
   logic        sat_rst;
   logic        s_rdy, s_stall;
   logic [3:0]  s_fwd_a, s_fwd_b;
   logic [15:0] s_cnt;

   pipe_scoreboard #(.DEPTH(D), .REG_AW(5), .ALU_READY(ALU_RDY), .LOAD_READY(LOAD_RDY)) u_dut (
      .clk(clk), .reset(reset),
      .issue_valid(issue_valid), .issue_wen(issue_wen), .issue_load(issue_load), .issue_rd(issue_rd),
      .src_a(src_a), .src_b(src_b), .src_a_used(src_a_used), .src_b_used(src_b_used),
      .flush(flush), .hold(hold),
      .issue_ready(issue_ready), .stall(stall), .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_count(stall_count)
   );

   pipe_scoreboard #(.DEPTH(8), .REG_AW(5), .ALU_READY(2), .LOAD_READY(8)) u_sat (
      .clk(clk), .reset(sat_rst),
      .issue_valid(1'b1), .issue_wen(1'b1), .issue_load(1'b1), .issue_rd(5'd5),
      .src_a(5'd5), .src_b(5'd0), .src_a_used(1'b1), .src_b_used(1'b0),
      .flush(1'b0), .hold(1'b0),
      .issue_ready(s_rdy), .stall(s_stall), .fwd_a(s_fwd_a), .fwd_b(s_fwd_b), .stall_count(s_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input int got, input int exp);
      n_checks++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct {
      bit vld;
      bit wen;
      bit load;
      int rd;
   } ent_t;

   typedef struct {
      int a;
      int b;
   } fwd_t;

   ent_t m [1:D];
   fwd_t fwd_q [$];
   int   m_cnt;
   int   m_fa, m_fb;

   task automatic model_reset();
      for (int k = 1; k <= D; k++) begin
         m[k].vld = 0; m[k].wen = 0; m[k].load = 0; m[k].rd = 0;
      end
      m_cnt = 0; m_fa = 0; m_fb = 0;
      fwd_q.delete();
   endtask

   // search youngest-first, stop at the first hit
   task automatic lookup(input int src, input bit used, output int sel, output bit late);
      sel = 0; late = 0;
      for (int k = 1; k < D; k++) begin
         if (sel == 0 && used && src != 0 && m[k].vld && m[k].wen && m[k].rd == src) begin
            sel  = k + 1;
            late = (k + 1) < (m[k].load ? LOAD_RDY : ALU_RDY);
         end
      end
   endtask

   task automatic drive(input bit v, input bit wen, input bit ld, input int rd,
                        input int a, input bit au, input int b, input bit bu,
                        input bit fl, input bit hd);
      issue_valid = v; issue_wen = wen; issue_load = ld; issue_rd = rd[4:0];
      src_a = a[4:0]; src_a_used = au; src_b = b[4:0]; src_b_used = bu;
      flush = fl; hold = hd;
   endtask

   task automatic idle();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   // one cycle: called just after a negedge with inputs driven, returns at the next negedge
   task automatic tick(input string tag);
      int   sel_a, sel_b;
      bit   late_a, late_b, m_stall, m_rdy;
      fwd_t e;
      #1;
      lookup(int'(src_a), src_a_used, sel_a, late_a);
      lookup(int'(src_b), src_b_used, sel_b, late_b);
      m_stall = issue_valid && !flush && (late_a || late_b);
      m_rdy   = issue_valid && !m_stall && !hold && !flush;
      check({tag, "_stall"}, int'(stall), int'(m_stall));
      check({tag, "_rdy"}, int'(issue_ready), int'(m_rdy));
      check({tag, "_cnt"}, int'(stall_count), m_cnt);
      if (m_rdy) begin
         e.a = sel_a; e.b = sel_b;
         fwd_q.push_back(e);
      end
      @(posedge clk);
      if (!hold) begin
         for (int k = D; k >= 2; k--) m[k] = m[k-1];
         if (flush) m[2].vld = 0;
         m[1].vld = m_rdy; m[1].wen = issue_wen; m[1].load = issue_load; m[1].rd = int'(issue_rd);
         if (m_stall && m_cnt < 65535) m_cnt++;
         if (!m_rdy) begin m_fa = 0; m_fb = 0; end
      end
      @(negedge clk);
      if (fwd_q.size() > 0) begin
         e = fwd_q.pop_front();
         m_fa = e.a; m_fb = e.b;
      end
      check({tag, "_fwd_a"}, int'(fwd_a), m_fa);
      check({tag, "_fwd_b"}, int'(fwd_b), m_fb);
   endtask

   task automatic drain();
      idle();
      repeat (3) tick("drain");
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // ---------------- reset state ----------------
      reset = 1'b0; sat_rst = 1'b0;
      model_reset();
      drive(1, 1, 0, 3, 3, 1, 0, 0, 0, 0);
      #2;
      check("rst_stall", int'(stall), 0);
      check("rst_rdy", int'(issue_ready), 1);
      check("rst_fwd_a", int'(fwd_a), 0);
      check("rst_fwd_b", int'(fwd_b), 0);
      check("rst_cnt", int'(stall_count), 0);
      hold = 1'b1;
      #1;
      check("rst_rdy_hold", int'(issue_ready), 0);
      @(negedge clk);
      reset = 1'b1;
      idle();

      // ALU producer then immediate consumer: no stall, forward from stage 2
      drive(1, 1, 0, 3, 0, 0, 0, 0, 0, 0); tick("alu_r3");
      drive(1, 1, 0, 6, 3, 1, 0, 0, 0, 0); tick("use_r3");
      check("alu_fwd_a", int'(fwd_a), 2);
      drain();

      // load producer: one stall cycle, then forward from stage 3
      drive(1, 1, 1, 5, 0, 0, 0, 0, 0, 0); tick("ld_r5");
      drive(1, 1, 0, 6, 0, 0, 5, 1, 0, 0); tick("use_r5_stall");
      drive(1, 1, 0, 6, 0, 0, 5, 1, 0, 0); tick("use_r5_go");
      check("ld_cnt", int'(stall_count), 1);
      check("ld_fwd_b", int'(fwd_b), 3);
      drain();

      // two writers of r4: youngest wins; r0 never matches
      drive(1, 1, 0, 4, 0, 0, 0, 0, 0, 0); tick("w4_old");
      drive(1, 1, 0, 4, 0, 0, 0, 0, 0, 0); tick("w4_new");
      drive(1, 1, 0, 7, 4, 1, 0, 0, 0, 0); tick("use_r4");
      check("young_fwd_a", int'(fwd_a), 2);
      drive(1, 1, 1, 0, 0, 0, 0, 0, 0, 0); tick("ld_r0");
      drive(1, 1, 0, 7, 0, 1, 0, 1, 0, 0); tick("use_r0");
      check("r0_fwd_a", int'(fwd_a), 0);
      drain();

      // flush during a load hazard
      drive(1, 1, 1, 5, 0, 0, 0, 0, 0, 0); tick("fl_ld");
      drive(1, 1, 0, 6, 5, 1, 0, 0, 0, 0);
      #1;
      check("fl_pre_stall", int'(stall), 1);
      flush = 1'b1;
      tick("fl_cyc");
      drive(1, 1, 0, 6, 5, 1, 0, 0, 0, 0); tick("fl_after");
      check("fl_fwd_a", int'(fwd_a), 0);
      drain();

      // hold for 3 cycles while a load hazard is pending
      drive(1, 1, 0, 7, 0, 0, 0, 0, 0, 0); tick("hd_alu");
      drive(1, 1, 1, 5, 7, 1, 0, 0, 0, 0); tick("hd_ld");
      drive(1, 1, 0, 6, 0, 0, 5, 1, 0, 1);
      repeat (3) tick("hd_freeze");
      check("hd_cnt", int'(stall_count), 1);
      check("hd_fwd_a", int'(fwd_a), 2);
      drive(1, 1, 0, 6, 0, 0, 5, 1, 0, 0); tick("hd_rel_stall");
      drive(1, 1, 0, 6, 0, 0, 5, 1, 0, 0); tick("hd_rel_go");
      check("hd_cnt2", int'(stall_count), 2);
      check("hd_fwd_b", int'(fwd_b), 3);
      drain();

      // reset mid-operation with a hazard pending
      drive(1, 1, 1, 5, 0, 0, 0, 0, 0, 0); tick("mr_ld");
      drive(1, 1, 0, 6, 0, 0, 5, 1, 0, 0);
      #1 reset = 1'b0;
      #1;
      check("mr_stall", int'(stall), 0);
      check("mr_rdy", int'(issue_ready), 1);
      check("mr_fwd_a", int'(fwd_a), 0);
      check("mr_cnt", int'(stall_count), 0);
      reset = 1'b1;
      model_reset();
      tick("mr_after");
      check("mr_fwd_b", int'(fwd_b), 0);
      drain();

      // ---------------- saturation on the DEPTH=8 instance ----------------
      @(negedge clk);
      sat_rst = 1'b1;
      repeat (700) @(posedge clk);
      @(negedge clk);
      check("sat_700", int'(s_cnt), 600);
      repeat (76300) @(posedge clk);
      @(negedge clk);
      check("sat_ffff", int'(s_cnt), 65535);
      #1 sat_rst = 1'b0;
      #1;
      check("sat_rst_cnt", int'(s_cnt), 0);
      check("sat_rst_stall", int'(s_stall), 0);
      check("sat_rst_rdy", int'(s_rdy), 1);
      check("sat_rst_fwd", int'(s_fwd_a) + int'(s_fwd_b), 0);
      sat_rst = 1'b1;
      #1;
      check("sat_rel_stall", int'(s_stall), 0);
      @(negedge clk);
      check("sat_rel_cnt", int'(s_cnt), 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/pipe_scoreboard.md
PIPE_SCOREBOARD -- requirements
Module: pipe_scoreboard

Interface
REQ-001 SHALL have parameter DEPTH, default 3, meaning the number of tracked post-decode stages (1=EX, DEPTH=WB); legal range 2..8.
REQ-002 SHALL have parameter REG_AW, default 5, meaning the register-index width.
REQ-003 SHALL have parameter ALU_READY, default 2, meaning the first stage index at which a non-load result can be forwarded.
REQ-004 SHALL have parameter LOAD_READY, default 3, meaning the first stage index at which a load result can be forwarded; it must satisfy ALU_READY <= LOAD_READY <= DEPTH.
REQ-005 SHALL define FW = clog2(DEPTH+1) as the width of the forward selects.
REQ-006 Ports (one clock; reset is asynchronous and active-low):
  clk  in  1  rising-edge clock
  reset  in  1  asynchronous active-low reset
  issue_valid  in  1  decode presents an instruction
  issue_wen  in  1  instruction writes a register
  issue_load  in  1  instruction is a load
  issue_rd  in  REG_AW  destination register
  src_a, src_b  in  REG_AW  source registers
  src_a_used, src_b_used  in  1  the corresponding source is read
  flush  in  1  squash the decode instruction and the EX-stage instruction
  hold  in  1  global freeze (memory wait)
  issue_ready  out  1  issue accepted this cycle
  stall  out  1  data-hazard stall (combinational)
  fwd_a, fwd_b  out  FW  forward selects for the instruction in EX: 0 = register file, k = stage k
  stall_count  out  16  saturating count of stall cycles

Function
REQ-007 SHALL keep one entry {valid, wen, load, rd} per stage k = 1..DEPTH.
REQ-008 A source SHALL match entry k when all hold: src_x_used=1, entry valid, entry wen=1, entry rd == src_x, and src_x != 0.
REQ-009 Only stages 1..DEPTH-1 SHALL be matched; the stage-DEPTH entry writes the register file this cycle, and the register file is write-before-read.
REQ-010 Among matching entries, the one with the lowest k (youngest) SHALL be selected; older matches are ignored.
REQ-011 For the selected entry, ready_stage SHALL be LOAD_READY if the entry is a load, else ALU_READY.
REQ-012 stall SHALL be 1 when issue_valid=1, flush=0, and for either source the selected entry satisfies k+1 < ready_stage.
REQ-013 issue_ready SHALL equal issue_valid & ~stall & ~hold & ~flush.
REQ-014 On a clock edge with hold=0, every entry k SHALL shift to k+1, and the stage-DEPTH entry SHALL retire.
REQ-015 On the same edge, stage 1 SHALL load {1, issue_wen, issue_load, issue_rd} when issue_ready=1, else a bubble (valid=0).
REQ-016 On the same edge, fwd_a/fwd_b SHALL register (selected k)+1 per source, or 0 if no match, when issue_ready=1; otherwise they are cleared to 0.
REQ-017 flush=1 with hold=0 SHALL write stage 2 as a bubble instead of the old stage-1 entry, and SHALL load stage 1 as a bubble.
REQ-018 flush SHALL take priority over stall and issue_valid.
REQ-019 hold=1 SHALL freeze all entries, fwd_a/fwd_b and stall_count; stall remains combinationally valid during hold.
REQ-020 stall_count SHALL increment on each edge where stall=1 and hold=0, and saturate at 16'hFFFF.
REQ-021 Latency: the forward select for an issued instruction SHALL be valid exactly one cycle after issue, while that instruction occupies stage 1.
REQ-022 A stalled instruction SHALL be re-evaluated every cycle until it is accepted; no internal state holds the pending instruction.

Reset
REQ-023 reset=0 SHALL immediately clear all entries to invalid, fwd_a=fwd_b=0 and stall_count=0, independent of clk.
REQ-024 Reset asserted mid-operation SHALL discard all in-flight entries; the first issue after reset release SHALL see no hazards.
REQ-025 Combinational outputs during reset SHALL reflect the cleared state: stall=0, and issue_ready = issue_valid & ~hold & ~flush.

Verification (DEPTH=3, ALU_READY=2, LOAD_READY=3)
REQ-026 ALU r3 issued, then a consumer with src_a=3 issued the next cycle -> no stall; fwd_a=2 one cycle later.
REQ-027 Load to r5, then a consumer with src_b=5 -> stall=1 for exactly one cycle and stall_count=1; the consumer is then accepted with fwd_b=3.
REQ-028 Writes to r4 at stages 1 and 2, then a consumer with src_a=4 -> fwd_a=2 (youngest wins); a consumer with src_a=0 -> fwd_a=0 and no stall.
REQ-029 Load to r5 in stage 1 with a consumer stalled, then flush=1 -> stall=0, issue_ready=0, stage 2 becomes a bubble; the next-cycle issue of src=5 -> fwd=0.
REQ-030 hold=1 for 3 cycles while a load hazard is pending -> entries and stall_count unchanged, stall=1 throughout; release -> normal progression.
REQ-031 Force 70000 stall cycles -> stall_count=16'hFFFF; pulse reset low mid-cycle -> stall_count=0 and all entries invalid before the next edge.
